glm_bram_arbiter: RTL and testbench

Round-robin arbiter that shares one cache-line BRAM (512-bit data, 2^LOG2_MEMORY_SIZE lines, `bram_access` layout) between NUM_REQ requesters, such as the program loader, prefetcher and execution units of the GLM engine. Each cycle it grants at most one read or write request and drives the BRAM port from registers. It tracks in-flight reads with a tag pipeline so that read data is steered back to the requester that issued it.

---
 rtl/glm_bram_arbiter_if.sv | 36 +++
 rtl/glm_bram_arbiter.sv | 108 ++++++++++
 tb/tb_glm_bram_arbiter.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/glm_bram_arbiter_if.sv
// Request, BRAM-port and read-return bundle for glm_bram_arbiter.
// slave = arbiter side, master = requesters plus BRAM model side.
interface glm_bram_arbiter_if #(
    parameter int NUM_REQ          = 4,
    parameter int LOG2_MEMORY_SIZE = 10
);
    logic [NUM_REQ-1:0]                  req_valid;
    logic [NUM_REQ-1:0]                  req_we;
    logic [NUM_REQ*LOG2_MEMORY_SIZE-1:0] req_addr;
    logic [NUM_REQ*512-1:0]              req_wdata;
    logic [NUM_REQ-1:0]                  req_ready;

    logic                                bram_we;
    logic [LOG2_MEMORY_SIZE-1:0]         bram_waddr;
    logic [511:0]                        bram_wdata;
    logic                                bram_re;
    logic [LOG2_MEMORY_SIZE-1:0]         bram_raddr;
    logic [511:0]                        bram_rdata;
    logic                                bram_rvalid;

    logic [NUM_REQ-1:0]                  rd_valid;
    logic [511:0]                        rd_data;
    logic                                err_mismatch;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, bram_rdata, bram_rvalid,
        output req_ready, bram_we, bram_waddr, bram_wdata, bram_re, bram_raddr,
               rd_valid, rd_data, err_mismatch
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata, bram_rdata, bram_rvalid,
        input  req_ready, bram_we, bram_waddr, bram_wdata, bram_re, bram_raddr,
               rd_valid, rd_data, err_mismatch
    );
endinterface

// File: rtl/glm_bram_arbiter.sv
// Round-robin arbiter sharing one 512-bit cache-line BRAM between NUM_REQ requesters,
// with a tag pipeline that steers read data back to the requester that issued the read.
module glm_bram_arbiter #(
    parameter int NUM_REQ          = 4,
    parameter int READ_LATENCY     = 2,
    parameter int LOG2_MEMORY_SIZE = 10
) (
    input  logic              clk_i,
    input  logic              resetn_i,
    glm_bram_arbiter_if.slave bus
);
    localparam int PTR_W = $clog2(NUM_REQ);
    // One stage per BRAM latency cycle plus the cycle the read sits on the port.
    localparam int TAG_DEPTH = READ_LATENCY + 1;
    localparam int MASK_W = 3;
    localparam logic [MASK_W-1:0] MASK_INIT = MASK_W'(READ_LATENCY + 1);

    logic [PTR_W-1:0]            rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]            winner;
    logic [PTR_W:0]              sum;
    logic                        found;
    logic                        xfer;
    logic                        sel_we;
    logic [LOG2_MEMORY_SIZE-1:0] sel_addr;
    logic [511:0]                sel_wdata;

    logic                        bram_we_q, bram_re_q;
    logic [LOG2_MEMORY_SIZE-1:0] waddr_q, raddr_q;
    logic [511:0]                wdata_q;
    logic [TAG_DEPTH-1:0]        tag_vld_q;
    logic [PTR_W-1:0]            tag_id_q [TAG_DEPTH];
    logic [NUM_REQ-1:0]          rd_valid_q;
    logic [511:0]                rd_data_q;
    logic                        err_q;
    logic [MASK_W-1:0]           mask_q;

    always_comb begin
        winner = '0;
        found  = 1'b0;
        sum    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
            if (sum >= (PTR_W+1)'(NUM_REQ)) sum = sum - (PTR_W+1)'(NUM_REQ);
            if (!found && bus.req_valid[sum[PTR_W-1:0]]) begin
                found  = 1'b1;
                winner = sum[PTR_W-1:0];
            end
        end
    end

    assign xfer      = found && resetn_i;
    assign sel_we    = bus.req_we[winner];
    assign sel_addr  = bus.req_addr[winner*LOG2_MEMORY_SIZE +: LOG2_MEMORY_SIZE];
    assign sel_wdata = bus.req_wdata[winner*512 +: 512];

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (xfer) rr_ptr_d = (winner == PTR_W'(NUM_REQ - 1)) ? '0 : winner + PTR_W'(1);
    end

    assign bus.req_ready = xfer ? (NUM_REQ'(1) << winner) : '0;

    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            rr_ptr_q   <= '0;
            bram_we_q  <= 1'b0;
            bram_re_q  <= 1'b0;
            waddr_q    <= '0;
            raddr_q    <= '0;
            wdata_q    <= '0;
            tag_vld_q  <= '0;
            for (int s = 0; s < TAG_DEPTH; s++) tag_id_q[s] <= '0;
            rd_valid_q <= '0;
            rd_data_q  <= '0;
            err_q      <= 1'b0;
            mask_q     <= MASK_INIT;
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            bram_we_q <= xfer && sel_we;
            bram_re_q <= xfer && !sel_we;
            if (xfer && sel_we) begin
                waddr_q <= sel_addr;
                wdata_q <= sel_wdata;
            end
            if (xfer && !sel_we) raddr_q <= sel_addr;

            tag_vld_q   <= {tag_vld_q[TAG_DEPTH-2:0], xfer && !sel_we};
            tag_id_q[0] <= winner;
            for (int s = 1; s < TAG_DEPTH; s++) tag_id_q[s] <= tag_id_q[s-1];

            rd_valid_q <= tag_vld_q[TAG_DEPTH-1] ? (NUM_REQ'(1) << tag_id_q[TAG_DEPTH-1]) : '0;
            if (tag_vld_q[TAG_DEPTH-1]) rd_data_q <= bus.bram_rdata;

            // Returns for reads dropped by a reset may still arrive; ignore them.
            if (mask_q != '0) mask_q <= mask_q - MASK_W'(1);
            else if (bus.bram_rvalid != tag_vld_q[TAG_DEPTH-1]) err_q <= 1'b1;
        end
    end

    assign bus.bram_we      = bram_we_q;
    assign bus.bram_waddr   = waddr_q;
    assign bus.bram_wdata   = wdata_q;
    assign bus.bram_re      = bram_re_q;
    assign bus.bram_raddr   = raddr_q;
    assign bus.rd_valid     = rd_valid_q;
    assign bus.rd_data      = rd_data_q;
    assign bus.err_mismatch = err_q;
endmodule

// File: tb/tb_glm_bram_arbiter.sv
// Scoreboard bench for glm_bram_arbiter: directed stimulus pushes expected BRAM ops and
// read returns into queues; monitors pop and compare when the DUT presents them.
module tb_glm_bram_arbiter;
    localparam int N = 4;
    localparam int L = 2;
    localparam int AW = 10;

    typedef struct { bit we; logic [AW-1:0] addr; logic [511:0] data; int t; } op_t;
    typedef struct { int id; logic [511:0] data; int t; } rd_t;

    logic clk = 1'b0;
    logic resetn;
    bit   mon_en = 1'b0;
    bit   inj = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    op_t  op_q[$];
    rd_t  rd_q[$];

    glm_bram_arbiter_if #(.NUM_REQ(N), .LOG2_MEMORY_SIZE(AW)) bus ();

    glm_bram_arbiter #(.NUM_REQ(N), .READ_LATENCY(L), .LOG2_MEMORY_SIZE(AW)) dut (
        .clk_i    (clk),
        .resetn_i (resetn),
        .bus      (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [511:0] init_word(input logic [AW-1:0] a);
        logic [31:0] w;
        w = {16'hBEEF, 6'd0, a};
        return {16{w}};
    endfunction

    function automatic logic [511:0] wd(input int i);
        logic [31:0] w;
        w = 32'(i + 1) * 32'h1111_1111;
        return {16{w}};
    endfunction

    // BRAM model: read-before-write, fixed latency L, never reset.
    bit [511:0] mem [1024];
    bit         wr  [1024];
    bit [1:0]   pv;
    logic [511:0] pd0, pd1;
    always @(posedge clk) begin
        if (bus.bram_we === 1'b1) begin
            mem[bus.bram_waddr] <= bus.bram_wdata;
            wr[bus.bram_waddr]  <= 1'b1;
        end
        pv  <= {pv[0], bus.bram_re === 1'b1};
        pd0 <= wr[bus.bram_raddr] ? mem[bus.bram_raddr] : init_word(bus.bram_raddr);
        pd1 <= pd0;
    end
    assign bus.bram_rvalid = pv[1] | inj;
    assign bus.bram_rdata  = pd1;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    op_t eo;
    always @(negedge clk) begin
        if (mon_en && (bus.bram_we || bus.bram_re)) begin
            if (op_q.size() == 0) begin
                chk("op_unexpected", 512'({bus.bram_we, bus.bram_re}), 512'(0));
            end else begin
                eo = op_q.pop_front();
                chk("op_we", 512'(bus.bram_we), 512'(eo.we));
                chk("op_re", 512'(bus.bram_re), 512'(!eo.we));
                chk("op_addr", 512'(eo.we ? bus.bram_waddr : bus.bram_raddr), 512'(eo.addr));
                if (eo.we) chk("op_wdata", bus.bram_wdata, eo.data);
                chk("op_cycle", 512'(cyc), 512'(eo.t));
            end
        end
    end

    rd_t er;
    logic [N-1:0] er_oh;
    always @(negedge clk) begin
        if (mon_en && bus.rd_valid != '0) begin
            if (rd_q.size() == 0) begin
                chk("rd_unexpected", 512'(bus.rd_valid), 512'(0));
            end else begin
                er = rd_q.pop_front();
                er_oh = 4'b0001 << er.id;
                chk("rd_valid", 512'(bus.rd_valid), 512'(er_oh));
                chk("rd_data", bus.rd_data, er.data);
                chk("rd_cycle", 512'(cyc), 512'(er.t));
            end
        end
    end

    task automatic set_req(input int i, input bit we, input logic [AW-1:0] a, input logic [511:0] d);
        bus.req_we[i] = we;
        bus.req_addr[i*AW +: AW] = a;
        bus.req_wdata[i*512 +: 512] = d;
    endtask

    // Called at #1 after a posedge; checks the grant and records what must follow.
    task automatic issue(input int id, input bit we, input logic [AW-1:0] addr,
                         input logic [511:0] data, input bit exp_rd);
        op_t o;
        rd_t r;
        logic [N-1:0] oh;
        @(negedge clk);
        oh = 4'b0001 << id;
        chk("grant", 512'(bus.req_ready), 512'(oh));
        o.we = we; o.addr = addr; o.data = data; o.t = cyc + 1;
        op_q.push_back(o);
        if (!we && exp_rd) begin
            r.id = id; r.data = data; r.t = cyc + 2 + L;
            rd_q.push_back(r);
        end
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            chk("idle_ready", 512'(bus.req_ready), 512'(0));
            @(posedge clk); #1;
        end
    endtask

    initial begin
        resetn = 1'b0;
        bus.req_valid = '1;
        bus.req_we    = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;

        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            chk("rst_ready", 512'(bus.req_ready), 512'(0));
        end
        chk("rst_bram_we", 512'(bus.bram_we), 512'(0));
        chk("rst_bram_re", 512'(bus.bram_re), 512'(0));
        chk("rst_err", 512'(bus.err_mismatch), 512'(0));
        chk("rst_rd_valid", 512'(bus.rd_valid), 512'(0));
        @(posedge clk); #1;
        resetn = 1'b1;
        bus.req_valid = '0;
        mon_en = 1'b1;

        // Fairness: all four writing continuously.
        for (int i = 0; i < N; i++) set_req(i, 1'b1, AW'(10'h100 + i), wd(i));
        bus.req_valid = 4'b1111;
        for (int k = 0; k < 2 * N; k++) issue(k % N, 1'b1, AW'(10'h100 + k % N), wd(k % N), 1'b0);
        issue(0, 1'b1, 10'h100, wd(0), 1'b0);
        bus.req_valid = '0;
        idle(2);

        // Single read by requester 2 (pointer at 1).
        set_req(2, 1'b0, 10'h3FF, '0);
        bus.req_valid = 4'b0100;
        issue(2, 1'b0, 10'h3FF, {16{32'hBEEF_03FF}}, 1'b1);
        bus.req_valid = '0;
        idle(6);

        // Pointer at 3, only requester 0: search wraps.
        set_req(0, 1'b1, 10'h020, {64{8'h3C}});
        bus.req_valid = 4'b0001;
        issue(0, 1'b1, 10'h020, {64{8'h3C}}, 1'b0);

        // Write by 1 and read by 3 of the same line in the same cycle.
        set_req(1, 1'b1, 10'h010, {64{8'hA5}});
        set_req(3, 1'b0, 10'h010, '0);
        bus.req_valid = 4'b1010;
        issue(1, 1'b1, 10'h010, {64{8'hA5}}, 1'b0);
        bus.req_valid = 4'b1000;
        issue(3, 1'b0, 10'h010, {64{8'hA5}}, 1'b1);
        bus.req_valid = '0;
        idle(8);

        // Spurious return with nothing in flight.
        inj = 1'b1;
        @(negedge clk);
        chk("err_before", 512'(bus.err_mismatch), 512'(0));
        @(posedge clk); #1;
        inj = 1'b0;
        @(negedge clk);
        chk("err_set", 512'(bus.err_mismatch), 512'(1));
        @(posedge clk); #1;
        idle(3);
        chk("err_sticky", 512'(bus.err_mismatch), 512'(1));
        resetn = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        @(negedge clk);
        chk("err_cleared", 512'(bus.err_mismatch), 512'(0));
        @(posedge clk); #1;
        idle(5);

        // Reset one cycle after a read grant: return must be dropped silently.
        bus.req_valid = 4'b0100;
        issue(2, 1'b0, 10'h3FF, init_word(10'h3FF), 1'b0);
        resetn = 1'b0;
        bus.req_valid = '0;
        @(posedge clk); #1;
        resetn = 1'b1;
        idle(8);
        chk("midflight_err", 512'(bus.err_mismatch), 512'(0));

        chk("op_q_drained", 512'(op_q.size()), 512'(0));
        chk("rd_q_drained", 512'(rd_q.size()), 512'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
